// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants and types for the 16-port router matrix arbiters.
//   N_PORTS    : number of input ports (requesters) per output arbiter
//   ID_W       : width of a port index, clog2(N_PORTS)
//   MAX_HOLD   : watchdog limit in cycles (used only with ROUTER_ARB_TIMEOUT_EN)
//   HOLD_CNT_W : width of the watchdog hold counter, wide enough for MAX_HOLD
//   arb_state_t: arbiter FSM states
//   port_vec_t : one bit per input port
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int N_PORTS    = 16;
  localparam int ID_W       = 4;
  localparam int MAX_HOLD   = 1024;
  localparam int HOLD_CNT_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } arb_state_t;

  typedef logic [N_PORTS-1:0] port_vec_t;

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker, shared by the router arbiters.
// Picks the first set request bit scanning ptr, ptr+1, ... modulo N_PORTS.
// Ports:
//   request : per-port request vector
//   ptr     : index with highest priority this round
//   onehot  : one-hot of the chosen port, zero when nothing requests
//   id      : index of the chosen port, zero when nothing requests
//   any     : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
  import router_pkg::*;
(
  input  logic [N_PORTS-1:0] request,
  input  logic [ID_W-1:0]    ptr,
  output logic [N_PORTS-1:0] onehot,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  port_vec_t            upper_mask;
  logic [2*N_PORTS-1:0] dbl;
  logic [ID_W-1:0]      first_idx;

  // The low half holds only requests at or above ptr, the high half holds all
  // requests. The lowest set bit of the concatenation is therefore the first
  // requester at or after ptr, wrapping around; its index mod N_PORTS is the id.
  assign upper_mask = ~((port_vec_t'(1) << ptr) - port_vec_t'(1));
  assign dbl        = {request, request & upper_mask};
  assign any        = |request;

  // Priority encode, lowest bit wins (scan downward so the last hit is lowest).
  always_comb begin
    first_idx = '0;
    for (int i = 2*N_PORTS-1; i >= 0; i--) begin
      if (dbl[i]) first_idx = i[ID_W-1:0];
    end
  end

  assign id     = any ? first_idx : '0;
  assign onehot = any ? (port_vec_t'(1) << first_idx) : '0;

endmodule

// File: rtl/router_out_arbiter.sv
// ---------------------------------------------------------------------------
// router_out_arbiter
// Per-output-port arbiter of the router matrix. Grants one input at a time in
// round-robin order and holds the grant until that input's frame ends (or the
// input abandons its request before its frame starts). All outputs registered.
// Optional watchdog: define ROUTER_ARB_TIMEOUT_EN to revoke grants held for
// MAX_HOLD cycles; without it timeout is tied low and grants never expire.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   request  : per-input request, level, held until the frame ends
//   frame_n  : per-input active-low frame strobe
//   grant    : one-hot grant, zero when idle
//   grant_id : index of the granted input, zero when idle
//   busy     : a grant is held
//   timeout  : one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module router_out_arbiter
  import router_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_PORTS-1:0] request,
  input  logic [N_PORTS-1:0] frame_n,
  output logic [N_PORTS-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout
);

  arb_state_t      state, state_d;
  logic [ID_W-1:0] ptr, ptr_d;
  logic            frame_seen, frame_seen_d;
  port_vec_t       grant_d;
  logic [ID_W-1:0] grant_id_d;
  logic            busy_d;

  port_vec_t       pick_onehot;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;

  logic            frame_end;
  logic            abandon;
  logic            release_now;

  rr_pick u_pick (
    .request (request),
    .ptr     (ptr),
    .onehot  (pick_onehot),
    .id      (pick_id),
    .any     (pick_any)
  );

  // A frame ends on the first high frame_n after a low one was seen; an
  // input that drops its request before its frame ever started gives up.
  assign frame_end = frame_seen & frame_n[grant_id];
  assign abandon   = ~frame_seen & ~request[grant_id];

`ifdef ROUTER_ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic                  timeout_d;
  logic                  expire;

  assign expire      = (hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1));
  assign release_now = frame_end | abandon | expire;
`else
  assign release_now = frame_end | abandon;
  assign timeout     = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      frame_seen <= 1'b0;
      grant      <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
`ifdef ROUTER_ARB_TIMEOUT_EN
      hold_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      frame_seen <= frame_seen_d;
      grant      <= grant_d;
      grant_id   <= grant_id_d;
      busy       <= busy_d;
`ifdef ROUTER_ARB_TIMEOUT_EN
      hold_cnt   <= hold_cnt_d;
      timeout    <= timeout_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_any) state_d = HOLD;
      HOLD:    if (release_now) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath. Grant contents are
  // frozen during HOLD so other requests cannot preempt. ptr moves past the
  // released input so it gets lowest priority next round.
  always_comb begin
    grant_d      = grant;
    grant_id_d   = grant_id;
    busy_d       = busy;
    ptr_d        = ptr;
    frame_seen_d = frame_seen;
`ifdef ROUTER_ARB_TIMEOUT_EN
    hold_cnt_d   = hold_cnt;
    timeout_d    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_d      = pick_onehot;
          grant_id_d   = pick_id;
          busy_d       = 1'b1;
          frame_seen_d = 1'b0;
`ifdef ROUTER_ARB_TIMEOUT_EN
          hold_cnt_d   = '0;
`endif
        end
      end
      HOLD: begin
        if (release_now) begin
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
          ptr_d      = grant_id + ID_W'(1);
`ifdef ROUTER_ARB_TIMEOUT_EN
          // A frame ending on the limit cycle is a normal release.
          timeout_d  = expire & ~frame_end;
`endif
        end else begin
          frame_seen_d = frame_seen | ~frame_n[grant_id];
`ifdef ROUTER_ARB_TIMEOUT_EN
          hold_cnt_d   = hold_cnt + HOLD_CNT_W'(1);
`endif
        end
      end
      RELEASE: begin
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_router_out_arbiter
// Directed self-checking bench for router_out_arbiter. Inputs change and
// outputs are observed 1 time unit after each rising clock edge.
// Honours ROUTER_ARB_TIMEOUT_EN for the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_router_out_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] request;
  logic [15:0] frame_n;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        busy;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  router_out_arbiter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .request  (request),
    .frame_n  (frame_n),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset clears outputs asynchronously, first grant after reset is port 0,
  // and a reset in the middle of a grant clears it immediately.
  task automatic test_reset();
    $display("[TB] test_reset");
    reset_n = 1'b0;
    request = 16'hFFFF;
    frame_n = 16'hFFFF;
    #3;
    checks++; if (grant !== 16'h0000) begin errors++; $display("[TB] FAIL reset_grant: got %h expected %h", grant, 16'h0000); end
    checks++; if (grant_id !== 4'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d expected %0d", grant_id, 0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected %b", timeout, 1'b0); end
    step();
    step();
    checks++; if (grant !== 16'h0000) begin errors++; $display("[TB] FAIL reset_held_grant: got %h expected %h", grant, 16'h0000); end
    reset_n = 1'b1;
    step();
    checks++; if (grant !== 16'h0001) begin errors++; $display("[TB] FAIL first_grant: got %h expected %h", grant, 16'h0001); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_busy: got %b expected %b", busy, 1'b1); end
    reset_n = 1'b0;
    #2;
    checks++; if (grant !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset_grant: got %h expected %h", grant, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b expected %b", busy, 1'b0); end
    step();
    reset_n = 1'b1;
    request = 16'h0000;
  endtask

  // One request, a 10-cycle frame, grant drops one edge after frame_n rises.
  task automatic test_single_frame();
    $display("[TB] test_single_frame");
    request = 16'h0020;
    step();
    checks++; if (grant !== 16'h0020) begin errors++; $display("[TB] FAIL single_grant: got %h expected %h", grant, 16'h0020); end
    checks++; if (grant_id !== 4'd5) begin errors++; $display("[TB] FAIL single_grant_id: got %0d expected %0d", grant_id, 5); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected %b", busy, 1'b1); end
    frame_n[5] = 1'b0;
    repeat (10) step();
    checks++; if (grant !== 16'h0020) begin errors++; $display("[TB] FAIL single_hold: got %h expected %h", grant, 16'h0020); end
    frame_n[5] = 1'b1;
    request    = 16'h0000;
    step();
    checks++; if (grant !== 16'h0000) begin errors++; $display("[TB] FAIL single_release_grant: got %h expected %h", grant, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_release_busy: got %b expected %b", busy, 1'b0); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b expected %b", busy, 1'b0); end
  endtask

  // All inputs requesting from ptr=0: ids 0..15 then 0, two idle cycles apart.
  task automatic test_round_robin();
    $display("[TB] test_round_robin");
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    request = 16'hFFFF;
    for (int n = 0; n < 17; n++) begin
      int e;
      e = n % 16;
      step();
      checks++; if (grant_id !== 4'(e)) begin errors++; $display("[TB] FAIL rr_grant_id[%0d]: got %0d expected %0d", n, grant_id, e); end
      checks++; if (grant !== (16'h0001 << e)) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %h expected %h", n, grant, 16'h0001 << e); end
      frame_n[e] = 1'b0;
      repeat (4) step();
      frame_n[e] = 1'b1;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_gap1[%0d]: got %b expected %b", n, busy, 1'b0); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_gap2[%0d]: got %b expected %b", n, busy, 1'b0); end
    end
    request = 16'h0000;
  endtask

  // ptr=4 after serving input 3; 9 wins over 3, then 3 wraps in afterwards.
  // The 0208 request lands on the frame-end edge and must wait for IDLE.
  task automatic test_pointer_wrap();
    $display("[TB] test_pointer_wrap");
    request = 16'h0008;
    step();
    checks++; if (grant_id !== 4'd3) begin errors++; $display("[TB] FAIL wrap_setup_id: got %0d expected %0d", grant_id, 3); end
    frame_n[3] = 1'b0;
    step();
    frame_n[3] = 1'b1;
    request    = 16'h0208;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_release_busy: got %b expected %b", busy, 1'b0); end
    step();
    step();
    checks++; if (grant_id !== 4'd9) begin errors++; $display("[TB] FAIL wrap_first_id: got %0d expected %0d", grant_id, 9); end
    checks++; if (grant !== 16'h0200) begin errors++; $display("[TB] FAIL wrap_first_grant: got %h expected %h", grant, 16'h0200); end
    frame_n[9] = 1'b0;
    step();
    checks++; if (grant !== 16'h0200) begin errors++; $display("[TB] FAIL wrap_no_preempt: got %h expected %h", grant, 16'h0200); end
    frame_n[9] = 1'b1;
    request    = 16'h0008;
    step();
    step();
    step();
    checks++; if (grant_id !== 4'd3) begin errors++; $display("[TB] FAIL wrap_second_id: got %0d expected %0d", grant_id, 3); end
    frame_n[3] = 1'b0;
    step();
    frame_n[3] = 1'b1;
    request    = 16'h0000;
    step();
    step();
  endtask

  // Input 2 drops its request before its frame starts: release next edge,
  // ptr becomes 3 so input 3 beats input 2 afterwards.
  task automatic test_abandon();
    $display("[TB] test_abandon");
    request = 16'h0004;
    step();
    checks++; if (grant !== 16'h0004) begin errors++; $display("[TB] FAIL abandon_grant: got %h expected %h", grant, 16'h0004); end
    request = 16'h0000;
    step();
    checks++; if (grant !== 16'h0000) begin errors++; $display("[TB] FAIL abandon_release_grant: got %h expected %h", grant, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abandon_release_busy: got %b expected %b", busy, 1'b0); end
    request = 16'h000C;
    step();
    step();
    checks++; if (grant_id !== 4'd3) begin errors++; $display("[TB] FAIL abandon_ptr_id: got %0d expected %0d", grant_id, 3); end
    frame_n[3] = 1'b0;
    step();
    frame_n[3] = 1'b1;
    request    = 16'h0000;
    step();
    step();
  endtask

  // frame_n[7] stuck low for 1024 cycles.
  task automatic test_timeout();
    $display("[TB] test_timeout");
    request = 16'h0080;
    step();
    checks++; if (grant !== 16'h0080) begin errors++; $display("[TB] FAIL timeout_setup_grant: got %h expected %h", grant, 16'h0080); end
    frame_n[7] = 1'b0;
    repeat (1023) step();
    checks++; if (grant !== 16'h0080) begin errors++; $display("[TB] FAIL timeout_pre_grant: got %h expected %h", grant, 16'h0080); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pre_pulse: got %b expected %b", timeout, 1'b0); end
    step();
`ifdef ROUTER_ARB_TIMEOUT_EN
    checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_pulse: got %b expected %b", timeout, 1'b1); end
    checks++; if (grant !== 16'h0000) begin errors++; $display("[TB] FAIL timeout_revoke: got %h expected %h", grant, 16'h0000); end
`else
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_tied: got %b expected %b", timeout, 1'b0); end
    checks++; if (grant !== 16'h0080) begin errors++; $display("[TB] FAIL timeout_held: got %h expected %h", grant, 16'h0080); end
`endif
    request = 16'h0000;
    frame_n = 16'hFFFF;
    step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_one_cycle: got %b expected %b", timeout, 1'b0); end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_pointer_wrap();
    test_abandon();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
